// File: rtl/spike_rate_decoder.sv
// Decodes a LIF spike train into a per-window spike rate and the latest inter-spike interval.
// Define SPIKE_DECODER_EDGE_EN to count rising edges of spike_in instead of high cycles.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_LEN = 256,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ISI_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int unsigned WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;

  typedef enum logic [1:0] {
    NO_SPIKE  = 2'd0,
    ONE_SPIKE = 2'd1,
    TIMING    = 2'd2
  } isi_state_e;

  isi_state_e       state_q;
  logic [ISI_W-1:0] timer_q;
  logic [ISI_W-1:0] isi_last_q;

  logic [WIN_W-1:0] win_cnt_q,   win_cnt_d;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic [CNT_W-1:0] rate_q,      rate_d;
  logic [ISI_W-1:0] isi_q,       isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;

  logic             spike_c;
  logic             close_c;
  logic             load_c;
  logic [CNT_W-1:0] result_c;

`ifdef SPIKE_DECODER_EDGE_EN
  logic prev_q;

  // Previous enabled sample, so a held level only counts on its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (en) begin
      prev_q <= spike_in;
    end
  end

  assign spike_c = en & spike_in & ~prev_q;
`else
  assign spike_c = en & spike_in;
`endif

  assign close_c  = en && (win_cnt_q == WIN_LAST);
  assign load_c   = !out_valid_q || out_ready;
  assign result_c = (spike_c && (spike_cnt_q != CNT_MAX)) ? spike_cnt_q + CNT_W'(1) : spike_cnt_q;

  // ISI tracker: timer restarts at 1 on each spike; interval latched from the second spike on
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NO_SPIKE;
      timer_q    <= '0;
      isi_last_q <= '0;
    end else if (en) begin
      case (state_q)
        NO_SPIKE: begin
          if (spike_c) begin
            timer_q <= ISI_W'(1);
            state_q <= ONE_SPIKE;
          end
        end
        ONE_SPIKE, TIMING: begin
          if (spike_c) begin
            isi_last_q <= timer_q;
            timer_q    <= ISI_W'(1);
            state_q    <= TIMING;
          end else if (timer_q != ISI_MAX) begin
            timer_q <= timer_q + ISI_W'(1);
          end
        end
        default: state_q <= NO_SPIKE;
      endcase
    end
  end

  // Window accumulation, snapshot at close and valid/ready result stage
  always_comb begin
    win_cnt_d   = win_cnt_q;
    spike_cnt_d = spike_cnt_q;
    rate_d      = rate_q;
    isi_d       = isi_q;
    isi_valid_d = isi_valid_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (en) begin
      if (close_c) begin
        win_cnt_d   = '0;
        spike_cnt_d = '0;
        if (load_c) begin
          rate_d      = result_c;
          isi_d       = isi_last_q;
          isi_valid_d = (state_q == TIMING);
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        win_cnt_d   = win_cnt_q + WIN_W'(1);
        spike_cnt_d = result_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q   <= '0;
      spike_cnt_q <= '0;
      rate_q      <= '0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      spike_cnt_q <= spike_cnt_d;
      rate_q      <= rate_d;
      isi_q       <= isi_d;
      isi_valid_q <= isi_valid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_q;
  assign isi_valid = isi_valid_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: a 16-cycle-window decoder plus a narrow (CNT_W=3, ISI_W=2) copy for saturation.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic spike_in;
  logic out_ready;

  logic [7:0] rate_out, isi_out;
  logic       isi_valid, out_valid, overrun;
  logic [2:0] s_rate_out;
  logic [1:0] s_isi_out;
  logic       s_isi_valid, s_out_valid, s_overrun;

  int checks   = 0;
  int failures = 0;

  spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(8), .ISI_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_out(rate_out), .isi_out(isi_out), .isi_valid(isi_valid),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(3), .ISI_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_out(s_rate_out), .isi_out(s_isi_out), .isi_valid(s_isi_valid),
    .out_valid(s_out_valid), .out_ready(out_ready), .overrun(s_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int rate; int isi; int iv;
    int srate; int sisi; int siv;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; spike_in = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int rate, input int isi, input int iv,
                            input int srate, input int sisi, input int siv);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " rate"},      32'(rate_out),  32'(rate));
    chk({tag, " isi"},       32'(isi_out),   32'(isi));
    chk({tag, " isi_valid"}, 32'(isi_valid), 32'(iv));
    chk({tag, " sat rate"},  32'(s_rate_out),  32'(srate));
    chk({tag, " sat isi"},   32'(s_isi_out),   32'(sisi));
    chk({tag, " sat isi_valid"}, 32'(s_isi_valid), 32'(siv));
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; spike_in = 1'b0; out_ready = 1'b1;

    vecs[0] = '{16'h0000, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{16'h0008, 1, 0, 0, 1, 0, 0};
    vecs[2] = '{16'h1111, 4, 4, 1, 4, 3, 1};
    vecs[3] = '{16'h8001, 2, 0, 0, 2, 0, 0};
    vecs[4] = '{16'h0024, 2, 3, 1, 2, 3, 1};
    vecs[5] = '{16'h5555, 8, 2, 1, 7, 2, 1};
    vecs[6] = '{16'h0802, 2, 10, 1, 2, 3, 1};
    vecs[7] = '{16'h2208, 3, 4, 1, 3, 3, 1};

    // Reset state
    do_reset();
    chk("reset rate", 32'(rate_out), 32'd0);
    chk("reset isi", 32'(isi_out), 32'd0);
    chk("reset isi_valid", 32'(isi_valid), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);

    // Single-window vectors, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        spike_in = vecs[v].mask[i];
        tick();
        if (i == 14) chk($sformatf("vec%0d early valid", v), 32'(out_valid), 32'd0);
      end
      chk_result($sformatf("vec%0d", v), vecs[v].rate, vecs[v].isi, vecs[v].iv,
                 vecs[v].srate, vecs[v].sisi, vecs[v].siv);
      spike_in = 1'b0;
      tick();
      chk($sformatf("vec%0d valid drop", v), 32'(out_valid), 32'd0);
    end

    // Periodic spikes across three windows: one-cycle valid pulse per window
    do_reset();
    for (int t = 0; t < 48; t++) begin
      spike_in = (t % 4 == 0);
      tick();
      if (t % 16 == 15) chk_result($sformatf("periodic t%0d", t), 4, 4, 1, 4, 3, 1);
      else chk($sformatf("periodic t%0d valid", t), 32'(out_valid), 32'd0);
    end

    // Backpressure: first result held, second close dropped, overrun sticky
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      spike_in = (t < 16) ? (t % 4 == 0) : (t % 2 == 0);
      tick();
      chk($sformatf("bp t%0d overrun", t), 32'(overrun), 32'(t >= 31));
      if (t >= 15) begin
        chk($sformatf("bp t%0d valid", t), 32'(out_valid), 32'd1);
        chk($sformatf("bp t%0d rate", t), 32'(rate_out), 32'd4);
        chk($sformatf("bp t%0d isi", t), 32'(isi_out), 32'd4);
      end
    end
    out_ready = 1'b1;
    for (int t = 40; t < 48; t++) begin
      spike_in = (t % 2 == 0);
      tick();
      if (t < 47) chk($sformatf("bp t%0d drained", t), 32'(out_valid), 32'd0);
      chk($sformatf("bp t%0d overrun sticky", t), 32'(overrun), 32'd1);
    end
    chk_result("bp third window", 8, 2, 1, 7, 2, 1);

    // Close coinciding with a transfer: new result replaces old, no overrun
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 32; t++) begin
      spike_in = (t < 16) ? (t % 4 == 0) : (t % 2 == 0);
      out_ready = (t == 31);
      tick();
    end
    chk_result("same-cycle", 8, 2, 1, 7, 2, 1);
    chk("same-cycle overrun", 32'(overrun), 32'd0);
    out_ready = 1'b1; spike_in = 1'b0;
    tick();
    chk("same-cycle drop", 32'(out_valid), 32'd0);

    // en low for 10 cycles mid-window delays the close by 10; spikes ignored meanwhile
    do_reset();
    begin
      int k;
      k = 0;
      for (int n = 0; n < 26; n++) begin
        if (n >= 8 && n < 18) begin
          en = 1'b0; spike_in = 1'b1;
        end else begin
          en = 1'b1; spike_in = (k % 4 == 0); k++;
        end
        tick();
        if (n < 25) chk($sformatf("en gap n%0d valid", n), 32'(out_valid), 32'd0);
      end
    end
    chk_result("en gap", 4, 4, 1, 4, 3, 1);
    en = 1'b1;

    // Reset mid-window with a pending result and 3 counted spikes
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 25; t++) begin
      spike_in = (t < 16) ? (t % 4 == 0) : (t == 17 || t == 20 || t == 23);
      tick();
    end
    chk("pre-rst pending", 32'(out_valid), 32'd1);
    rst = 1'b1; spike_in = 1'b1;
    tick();
    rst = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
    chk("mid rst rate", 32'(rate_out), 32'd0);
    chk("mid rst isi", 32'(isi_out), 32'd0);
    chk("mid rst isi_valid", 32'(isi_valid), 32'd0);
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i == 5);
      tick();
    end
    chk_result("post rst", 1, 0, 0, 1, 0, 0);

    // spike_in held high for two windows
    do_reset();
    spike_in = 1'b1;
    for (int t = 0; t < 32; t++) begin
      tick();
`ifdef SPIKE_DECODER_EDGE_EN
      if (t == 15) chk_result("held w1", 1, 0, 0, 1, 0, 0);
      if (t == 31) chk_result("held w2", 0, 0, 0, 0, 0, 0);
`else
      if (t == 15) chk_result("held w1", 16, 1, 1, 7, 1, 1);
      if (t == 31) chk_result("held w2", 16, 1, 1, 7, 1, 1);
`endif
    end
    spike_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive side of the neuron spike interface: decodes a one-bit spike train from a LIF neuron back into numbers.
- Two measurements per observation window:
  - rate: spikes counted over a fixed window.
  - ISI: the most recent inter-spike interval.
- Results go out through a valid/ready register stage. Sits downstream of the post-synaptic neuron spike output, for readout or host logging.

Parameters:
- WINDOW_LEN, 256, enabled cycles per observation window; minimum 2.
- CNT_W, 8, width of the rate count; the count saturates.
- ISI_W, 8, width of the interval measurement; the interval saturates.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  accumulate enable; when 0, all counters and timers hold
- spike_in  in  1  spike train; each high cycle is one spike unless the optional feature is enabled
- rate_out  out  CNT_W  spike count of the last completed window
- isi_out  out  ISI_W  last complete inter-spike interval, snapshotted at window close
- isi_valid  out  1  isi_out is meaningful (two or more spikes seen since reset)
- out_valid  out  1  result registers hold an untransferred result
- out_ready  in  1  consumer accepts the result when out_valid & out_ready
- overrun  out  1  sticky: a completed window was dropped

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - All outputs 0, all counters 0, ISI FSM in NO_SPIKE.
  - Reset mid-window discards the partial window and any pending result. out_valid is 0 the cycle after rst is sampled.
- Sampling: spike_in is sampled only when en=1. With en=0, win_cnt, spike_cnt, the ISI timer and the FSM hold; the handshake still operates.
- Window counter: win_cnt counts 0..WINDOW_LEN-1 on enabled cycles, then wraps to 0.
- Spike counter: spike_cnt += 1 on each enabled spike, saturating at 2^CNT_W-1.
- Window close (enabled cycle with win_cnt==WINDOW_LEN-1):
  - Result = saturating spike_cnt + spike_in of that cycle.
  - Snapshot: rate_out, isi_out and isi_valid load with the result and current ISI values. out_valid=1 on the next cycle.
  - Counters: spike_cnt and win_cnt clear to 0.
  - Latency: result visible 1 cycle after the last window cycle.
- Handshake:
  - While out_valid=1 and out_ready=0, rate_out, isi_out and isi_valid are stable.
  - Transfer: out_valid & out_ready; out_valid drops the next cycle unless a new window closes.
  - Close while out_valid=1 and out_ready=0: the new result is dropped, the old result is kept, overrun <= 1. overrun is sticky until rst.
  - Close in the same cycle as a transfer: the new result loads and out_valid stays 1; no overrun.
- ISI FSM:
  - NO_SPIKE: on spike, timer <= 1, go to ONE_SPIKE.
  - ONE_SPIKE: on spike, isi_last <= timer, timer <= 1, go to TIMING. Otherwise timer += 1, saturating at 2^ISI_W-1.
  - TIMING: on spike, isi_last <= timer, timer <= 1. Otherwise timer += 1, saturating. isi_valid source = 1.
  - Interval definition: spikes at enabled cycles t0 and t1 give ISI = t1-t0. Consecutive cycles give 1; values clamp at 2^ISI_W-1.
  - A spike on the window-close cycle updates isi_last after the snapshot, so the snapshot holds the previous interval.
- Widths: all adds are unsigned, no wrap; saturation on every counter except win_cnt.

Optional Feature:
- Macro SPIKE_DECODER_EDGE_EN.
- Defined: a spike is a rising edge of spike_in, using a registered previous enabled sample that is cleared by rst. A level held high for N cycles counts once, and the ISI is measured between rising edges.
- Undefined: every high enabled cycle is a spike, as described above.

Test Plan:
Bench uses WINDOW_LEN=16, CNT_W=8, ISI_W=8, out_ready=1, en=1 unless noted.
- One-cycle spike every 4 cycles from release -> each window rate_out=4, isi_out=4, isi_valid=1; out_valid is a 1-cycle pulse every 16 cycles.
- No spikes -> rate_out=0, isi_out=0, isi_valid=0. Single spike at cycle 3 -> rate_out=1, isi_valid=0.
- spike_in held 1, CNT_W=3 build -> rate_out=7 (saturated), isi_out=1. With SPIKE_DECODER_EDGE_EN -> rate_out=1 in the first window, 0 afterwards.
- out_ready=0 for 40 cycles -> first result stays stable, overrun=1 after the second close. Raising out_ready then transfers the first result; overrun stays 1.
- en=0 for 10 cycles mid-window -> window close is delayed by exactly 10 cycles; counts are unchanged by spikes during en=0.
- rst asserted at win_cnt=9 with 3 spikes counted -> all outputs 0. The next window after release reports only post-reset spikes.
